// File: rtl/tensor_core_pkg.sv
// Shared types and helpers for the parametrised tensor core and its lanes.
package tensor_core_pkg;

  typedef enum logic [2:0] {
    OP_MATMUL = 3'b000,
    OP_ADD    = 3'b001,
    OP_RELU   = 3'b010,
    OP_MAC    = 3'b011
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Full-precision dot product width plus one bit for the accumulate term.
  function automatic int acc_width(input int w, input int dim);
    return 2 * w + $clog2(dim) + 1;
  endfunction

  // Clamp to the signed w-bit range; intermediate values must fit in 64 bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (value > max_v) return max_v;
    else if (value < min_v) return min_v;
    else return value;
  endfunction

endpackage

// File: rtl/tensor_core_lane.sv
// One output element of the tensor core: purely combinational datapath.
module tensor_core_lane
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 3,
  parameter int SATURATE   = 1
) (
  input  logic [DIM*DATA_WIDTH-1:0] a_row_i,
  input  logic [DIM*DATA_WIDTH-1:0] b_col_i,
  input  logic [DATA_WIDTH-1:0]     a_elem_i,
  input  logic [DATA_WIDTH-1:0]     b_elem_i,
  input  logic [DATA_WIDTH-1:0]     c_old_i,
  input  op_e                       op_i,
  output logic [DATA_WIDTH-1:0]     result_o
);

  localparam int AW = acc_width(DATA_WIDTH, DIM);

  logic signed [AW-1:0] dot_s;
  logic signed [AW-1:0] full_s;

  always_comb begin
    dot_s = '0;
    for (int k = 0; k < DIM; k++) begin
      dot_s = dot_s + AW'($signed(a_row_i[k*DATA_WIDTH +: DATA_WIDTH]))
                    * AW'($signed(b_col_i[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_comb begin
    case (op_i)
      OP_MATMUL: full_s = dot_s;
      OP_MAC:    full_s = dot_s + AW'($signed(c_old_i));
      OP_ADD:    full_s = AW'($signed(a_elem_i)) + AW'($signed(b_elem_i));
      OP_RELU:   full_s = a_elem_i[DATA_WIDTH-1] ? '0 : AW'($signed(a_elem_i));
      default:   full_s = '0;
    endcase
  end

  // ReLU output is always in range, so saturating it is a no-op.
  always_comb begin
    if (SATURATE != 0) result_o = DATA_WIDTH'(saturate(64'(full_s), DATA_WIDTH));
    else               result_o = full_s[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/param_tensor_core.sv
// DIMxDIM tensor core: latches operands on start, produces LANES elements per cycle.
module param_tensor_core
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 3,
  parameter int LANES      = 1,
  parameter int SATURATE   = 1
) (
  input  logic                               tensor_core_clock,
  input  logic                               reset_in,
  input  logic                               tensor_core_register_file_write_enable,
  input  logic                               should_start_tensor_core,
  input  logic [2:0]                         operation_select,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]      tensor_core_input1,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]      tensor_core_input2,
  output logic                               busy,
  output logic                               done,
  output logic [DIM*DIM*DATA_WIDTH-1:0]      tensor_core_output,
  output logic [1:0]                         dbg_state_o
);

  localparam int N  = DIM * DIM;
  localparam int MW = N * DATA_WIDTH;
  localparam int CW = $clog2(N + LANES + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [MW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic            done_q, done_d;
  logic            last_step;

  logic [LANES-1:0]                 lane_act;
  logic [LANES-1:0][CW-1:0]         lane_e;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_res;

  assign last_step = (32'(cnt_q) + LANES) >= N;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CW-1:0]            e_safe;
    logic [DIM*DATA_WIDTH-1:0] a_row;
    logic [DIM*DATA_WIDTH-1:0] b_col;
    int                       row;
    int                       col;

    assign lane_e[l]   = cnt_q + CW'(l);
    assign lane_act[l] = 32'(lane_e[l]) < N;
    // Idle lanes read element 0 so every select stays in range.
    assign e_safe      = lane_act[l] ? lane_e[l] : '0;

    always_comb begin
      row = 32'(e_safe) / DIM;
      col = 32'(e_safe) % DIM;
      for (int k = 0; k < DIM; k++) begin
        a_row[k*DATA_WIDTH +: DATA_WIDTH] = a_q[(row*DIM + k)*DATA_WIDTH +: DATA_WIDTH];
        b_col[k*DATA_WIDTH +: DATA_WIDTH] = b_q[(k*DIM + col)*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    tensor_core_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DIM       (DIM),
      .SATURATE  (SATURATE)
    ) u_lane (
      .a_row_i (a_row),
      .b_col_i (b_col),
      .a_elem_i(a_q[32'(e_safe)*DATA_WIDTH +: DATA_WIDTH]),
      .b_elem_i(b_q[32'(e_safe)*DATA_WIDTH +: DATA_WIDTH]),
      .c_old_i (c_q[32'(e_safe)*DATA_WIDTH +: DATA_WIDTH]),
      .op_i    (op_e'(op_q)),
      .result_o(lane_res[l])
    );
  end

  // Opcodes 1xx run the full job but leave C untouched.
  always_comb begin
    c_d = c_q;
    if (state_q == ST_COMPUTE && !op_q[2]) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_act[l]) c_d[32'(lane_e[l])*DATA_WIDTH +: DATA_WIDTH] = lane_res[l];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (should_start_tensor_core && !tensor_core_register_file_write_enable) begin
          a_d     = tensor_core_input1;
          b_d     = tensor_core_input2;
          op_d    = operation_select;
          cnt_d   = '0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        cnt_d = cnt_q + CW'(LANES);
        if (tensor_core_register_file_write_enable) state_d = ST_IDLE;
        else if (last_step)                         state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = !tensor_core_register_file_write_enable;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tensor_core_clock) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign busy               = (state_q != ST_IDLE);
  assign done               = done_q;
  assign tensor_core_output = c_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_param_tensor_core.sv
// Directed bench: saturating, wrapping and 4-lane instances driven from shared stimulus.
module tb_param_tensor_core;

  localparam int W  = 8;
  localparam int N  = 9;
  localparam int MW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op_sel = 3'b000;
  logic [MW-1:0] in1 = '0;
  logic [MW-1:0] in2 = '0;

  logic          busy_s, done_s, busy_w, done_w, busy_4, done_4;
  logic [MW-1:0] c_s, c_w, c_4;
  logic [1:0]    st_s, st_w, st_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_tensor_core #(.DATA_WIDTH(8), .DIM(3), .LANES(1), .SATURATE(1)) u_sat (
    .tensor_core_clock(clk), .reset_in(rst), .tensor_core_register_file_write_enable(we),
    .should_start_tensor_core(start), .operation_select(op_sel),
    .tensor_core_input1(in1), .tensor_core_input2(in2),
    .busy(busy_s), .done(done_s), .tensor_core_output(c_s), .dbg_state_o(st_s));

  param_tensor_core #(.DATA_WIDTH(8), .DIM(3), .LANES(1), .SATURATE(0)) u_wrap (
    .tensor_core_clock(clk), .reset_in(rst), .tensor_core_register_file_write_enable(we),
    .should_start_tensor_core(start), .operation_select(op_sel),
    .tensor_core_input1(in1), .tensor_core_input2(in2),
    .busy(busy_w), .done(done_w), .tensor_core_output(c_w), .dbg_state_o(st_w));

  param_tensor_core #(.DATA_WIDTH(8), .DIM(3), .LANES(4), .SATURATE(1)) u_l4 (
    .tensor_core_clock(clk), .reset_in(rst), .tensor_core_register_file_write_enable(we),
    .should_start_tensor_core(start), .operation_select(op_sel),
    .tensor_core_input1(in1), .tensor_core_input2(in2),
    .busy(busy_4), .done(done_4), .tensor_core_output(c_4), .dbg_state_o(st_4));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_mat(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    for (int e = 0; e < N; e++)
      check_eq($sformatf("%s[%0d]", tag, e), 64'(got[e*W +: W]), 64'(exp[e*W +: W]));
  endtask

  function automatic logic [MW-1:0] splat(input int v);
    logic [MW-1:0] m;
    for (int e = 0; e < N; e++) m[e*W +: W] = W'(v);
    return m;
  endfunction

  function automatic logic [MW-1:0] ident(input int scale);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < 3; r++) m[(r*3 + r)*W +: W] = W'(scale);
    return m;
  endfunction

  function automatic logic [MW-1:0] seq9();
    logic [MW-1:0] m;
    for (int e = 0; e < N; e++) m[e*W +: W] = W'(e + 1);
    return m;
  endfunction

  // Returns at the negedge following the edge that samples the start.
  task automatic start_job(input logic [2:0] op);
    @(negedge clk);
    op_sel = op;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_s) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [2:0] op,
                         input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    in1 = a;
    in2 = b;
    start_job(op);
    wait_done(tag);
  endtask

  task automatic measure(input bit use_l4, input int span,
                         output int done_at, output int busy_n, output int done_n);
    done_at = -1;
    busy_n  = 0;
    done_n  = 0;
    for (int i = 0; i < span; i++) begin
      if (use_l4 ? busy_4 : busy_s) busy_n++;
      if (use_l4 ? done_4 : done_s) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      @(negedge clk);
    end
  endtask

  int relu_a[9] = '{-5, 7, 0, -128, 127, -1, 1, -64, 64};
  int relu_e[9] = '{0, 7, 0, 0, 127, 0, 1, 0, 64};

  initial begin
    int            d_at, b_n, d_n, ds_n, dw_n, d4_n;
    logic [MW-1:0] ra, re, abort_exp;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy_s), 64'd0);
    check_eq("rst_done", 64'(done_s), 64'd0);
    check_eq("rst_state", 64'(st_s), 64'd0);
    check_mat("rst_c_sat", c_s, '0);
    check_mat("rst_c_l4", c_4, '0);
    rst = 1'b0;

    // Identity times 1..9, with handshake timing on the single-lane core.
    @(negedge clk);
    in1 = ident(1);
    in2 = seq9();
    start_job(3'b000);
    measure(1'b0, 14, d_at, b_n, d_n);
    check_eq("mm_done_edge", 64'(d_at), 64'd10);
    check_eq("mm_done_cycles", 64'(d_n), 64'd1);
    check_eq("mm_busy_cycles", 64'(b_n), 64'd10);
    check_mat("mm_sat", c_s, seq9());
    check_mat("mm_wrap", c_w, seq9());
    check_mat("mm_l4", c_4, seq9());

    run_job("mm127", 3'b000, splat(127), splat(127));
    check_mat("mm127_sat", c_s, splat(127));
    check_mat("mm127_wrap", c_w, splat(3));
    check_mat("mm127_l4", c_4, splat(127));

    run_job("add_pos", 3'b001, splat(100), splat(100));
    check_mat("add_pos_sat", c_s, splat(127));
    check_mat("add_pos_wrap", c_w, splat(-56));
    run_job("add_neg", 3'b001, splat(-100), splat(-100));
    check_mat("add_neg_sat", c_s, splat(-128));
    check_mat("add_neg_wrap", c_w, splat(56));
    run_job("add_mix", 3'b001, splat(5), splat(-7));
    check_mat("add_mix_sat", c_s, splat(-2));
    check_mat("add_mix_wrap", c_w, splat(-2));

    for (int e = 0; e < N; e++) begin
      ra[e*W +: W] = W'(relu_a[e]);
      re[e*W +: W] = W'(relu_e[e]);
    end
    run_job("relu", 3'b010, ra, splat(99));
    check_mat("relu_sat", c_s, re);
    check_mat("relu_wrap", c_w, re);
    check_mat("relu_l4", c_4, re);

    run_job("mm_ii", 3'b000, ident(1), ident(1));
    check_mat("mm_ii_sat", c_s, ident(1));
    run_job("mac", 3'b011, ident(1), ident(1));
    check_mat("mac_sat", c_s, ident(2));
    check_mat("mac_wrap", c_w, ident(2));
    check_mat("mac_l4", c_4, ident(2));

    run_job("unsup", 3'b100, splat(50), splat(50));
    check_mat("unsup_sat", c_s, ident(2));
    check_mat("unsup_l4", c_4, ident(2));

    // Abort on the 4th compute edge, with an ignored start and input churn mid-job.
    @(negedge clk);
    in1 = ident(1);
    in2 = seq9();
    start_job(3'b000);
    @(negedge clk);
    start  = 1'b1;
    op_sel = 3'b001;
    in1    = splat(9);
    in2    = splat(9);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    check_eq("abort_busy", 64'(busy_s), 64'd0);
    check_eq("abort_done", 64'(done_s), 64'd0);
    ds_n = 0;
    dw_n = 0;
    d4_n = 0;
    for (int i = 0; i < 14; i++) begin
      if (done_s) ds_n++;
      if (done_w) dw_n++;
      if (done_4) d4_n++;
      @(negedge clk);
    end
    check_eq("abort_no_done_sat", 64'(ds_n), 64'd0);
    check_eq("abort_no_done_wrap", 64'(dw_n), 64'd0);
    check_eq("abort_in_done_l4", 64'(d4_n), 64'd0);
    abort_exp = ident(2);
    for (int e = 0; e < 4; e++) abort_exp[e*W +: W] = W'(e + 1);
    check_mat("abort_sat", c_s, abort_exp);
    check_mat("abort_wrap", c_w, abort_exp);
    check_mat("abort_l4", c_4, seq9());

    // Four lanes: K=3, last cycle has three idle lanes.
    @(negedge clk);
    in1 = ident(1);
    in2 = seq9();
    start_job(3'b000);
    measure(1'b1, 7, d_at, b_n, d_n);
    check_eq("l4_done_edge", 64'(d_at), 64'd4);
    check_eq("l4_done_cycles", 64'(d_n), 64'd1);
    check_eq("l4_busy_cycles", 64'(b_n), 64'd4);
    check_mat("l4_mm", c_4, seq9());
    wait_done("l4_sat_tail");
    check_mat("l4_sat_mm", c_s, seq9());

    // Reset mid-job.
    @(negedge clk);
    in1 = splat(1);
    in2 = splat(1);
    start_job(3'b000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy_l4", 64'(busy_4), 64'd0);
    check_eq("midrst_busy_sat", 64'(busy_s), 64'd0);
    check_eq("midrst_done_l4", 64'(done_4), 64'd0);
    check_mat("midrst_l4", c_4, '0);
    check_mat("midrst_sat", c_s, '0);

    run_job("post_rst", 3'b001, splat(5), splat(-7));
    check_mat("post_rst_sat", c_s, splat(-2));
    check_mat("post_rst_l4", c_4, splat(-2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
